// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: ROM word fields, note/duration widths
// and the sequencer state encoding.
package music_defs;

  localparam int END_BIT  = 15;
  localparam int ADV_BIT  = 14;
  localparam int NOTE_MSB = 11;
  localparam int NOTE_LSB = 6;
  localparam int DUR_MSB  = 5;
  localparam int DUR_LSB  = 0;
  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FETCH      = 3'd1;
  localparam logic [2:0] ST_WAIT_ROM   = 3'd2;
  localparam logic [2:0] ST_ALLOC      = 3'd3;
  localparam logic [2:0] ST_WAIT_BEATS = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_FETCH      = ST_FETCH,
    S_WAIT_ROM   = ST_WAIT_ROM,
    S_ALLOC      = ST_ALLOC,
    S_WAIT_BEATS = ST_WAIT_BEATS,
    S_DONE       = ST_DONE
  } state_t;

  function automatic logic [NOTE_W-1:0] entry_note(input logic [15:0] word);
    return word[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [15:0] word);
    return word[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/song_sequencer_voice_picker.sv
// Combinational priority encoder: grants the lowest-index voice that is not busy.
module voice_picker #(
  parameter int NUM_VOICES = 3
) (
  input  logic [NUM_VOICES-1:0] busy,
  output logic [NUM_VOICES-1:0] grant,
  output logic                  none_free
);

  logic found_s;

  // lowest free voice wins
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!busy[i] && !found_s) begin
        grant[i] = 1'b1;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
    none_free = &busy;
  end

endmodule

// File: rtl/song_sequencer.sv
// Walks a song in ROM, hands each note to the lowest free voice and paces the
// song by counting beats; supports chords, rests, pause and restart.
module song_sequencer
  import music_defs::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int SONG_BITS  = 2,
  parameter int IDX_BITS   = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic                          new_song,
  input  logic [SONG_BITS-1:0]          song_sel,
  input  logic                          beat,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [15:0]                   rom_data,
  output logic [NOTE_W-1:0]             note_to_load,
  output logic [DUR_W-1:0]              duration_to_load,
  output logic [NUM_VOICES-1:0]         load_new_note,
  input  logic [NUM_VOICES-1:0]         done_with_note,
  output logic [NUM_VOICES-1:0]         voice_busy,
  output logic                          song_done
);

  localparam logic [IDX_BITS-1:0] IDX_MAX = {IDX_BITS{1'b1}};
  localparam logic [IDX_BITS-1:0] IDX_ONE = {{(IDX_BITS-1){1'b0}}, 1'b1};

  state_t                        state_r, state_s;
  logic [SONG_BITS-1:0]          song_r, song_s;
  logic [IDX_BITS-1:0]           index_r, index_s;
  logic [DUR_W-1:0]              cnt_r, cnt_s;
  logic [15:0]                   entry_r, entry_s;
  logic [NOTE_W-1:0]             note_r, note_s;
  logic [DUR_W-1:0]              dur_r, dur_s;
  logic [NUM_VOICES-1:0]         load_r, load_s;
  logic [NUM_VOICES-1:0]         busy_r, busy_s;
  logic                          done_r, done_s;
  logic [SONG_BITS+IDX_BITS-1:0] addr_r, addr_s;
  logic [NUM_VOICES-1:0]         grant_s;
  logic                          none_free_s;
  logic                          do_adv_s, do_inc_s;

  voice_picker #(.NUM_VOICES(NUM_VOICES)) u_picker (
    .busy      (busy_r),
    .grant     (grant_s),
    .none_free (none_free_s)
  );

  // sequencing decisions and next values of every register
  always_comb begin
    state_s  = state_r;
    song_s   = song_r;
    index_s  = index_r;
    cnt_s    = cnt_r;
    entry_s  = entry_r;
    note_s   = note_r;
    dur_s    = dur_r;
    load_s   = '0;
    done_s   = done_r;
    do_adv_s = 1'b0;
    do_inc_s = 1'b0;

    if (new_song) begin
      song_s  = song_sel;
      index_s = '0;
      done_s  = 1'b0;
      state_s = S_FETCH;
    end else if (play) begin
      case (state_r)
        S_FETCH:    state_s = S_WAIT_ROM;
        S_WAIT_ROM: begin
          entry_s = rom_data;
          state_s = S_ALLOC;
        end
        S_ALLOC: begin
          if (entry_r[END_BIT]) begin
            state_s = S_DONE;
            done_s  = 1'b1;
          end else if (entry_note(entry_r) == 6'd0) begin
            do_adv_s = 1'b1;
          end else if (none_free_s) begin
            state_s = S_ALLOC;
          end else begin
            load_s   = grant_s;
            note_s   = entry_note(entry_r);
            dur_s    = entry_dur(entry_r);
            do_adv_s = 1'b1;
          end
        end
        S_WAIT_BEATS: begin
          if (beat) begin
            cnt_s    = cnt_r - 6'd1;
            do_inc_s = (cnt_r <= 6'd1);
          end else begin
            cnt_s = cnt_r;
          end
        end
        default: state_s = state_r;
      endcase

      if (do_adv_s) begin
        if (entry_r[ADV_BIT] && (entry_dur(entry_r) != 6'd0)) begin
          cnt_s   = entry_dur(entry_r);
          state_s = S_WAIT_BEATS;
        end else begin
          do_inc_s = 1'b1;
        end
      end else begin
        do_inc_s = do_inc_s;
      end

      // running off the end of the table finishes the song rather than wrapping
      if (do_inc_s) begin
        if (index_r == IDX_MAX) begin
          state_s = S_DONE;
          done_s  = 1'b1;
        end else begin
          index_s = index_r + IDX_ONE;
          state_s = S_FETCH;
        end
      end else begin
        index_s = index_s;
      end
    end else begin
      state_s = state_r;
    end

    busy_s = (busy_r & ~done_with_note) | load_s;
    addr_s = {song_s, index_s};
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      song_r  <= '0;
      index_r <= '0;
      cnt_r   <= '0;
      entry_r <= 16'd0;
      note_r  <= '0;
      dur_r   <= '0;
      load_r  <= '0;
      busy_r  <= '0;
      done_r  <= 1'b0;
      addr_r  <= '0;
    end else begin
      state_r <= state_s;
      song_r  <= song_s;
      index_r <= index_s;
      cnt_r   <= cnt_s;
      entry_r <= entry_s;
      note_r  <= note_s;
      dur_r   <= dur_s;
      load_r  <= load_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      addr_r  <= addr_s;
    end
  end

  assign rom_addr         = addr_r;
  assign note_to_load     = note_r;
  assign duration_to_load = dur_r;
  assign load_new_note    = load_r;
  assign voice_busy       = busy_r;
  assign song_done        = done_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Randomized bench for song_sequencer against an entry-level behavioural model of
// the song walk, voice allocation and beat pacing.
module tb_song_sequencer;

  localparam int NV = 3;
  localparam int SB = 2;
  localparam int IB = 5;
  localparam int ENTRIES = 1 << IB;
  localparam int N_CYCLES = 6000;

  localparam int P_IDLE   = 0;
  localparam int P_FETCH  = 1;
  localparam int P_DECIDE = 2;
  localparam int P_BEATS  = 3;
  localparam int P_END    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          play = 1'b0;
  logic          new_song = 1'b0;
  logic [SB-1:0] song_sel = '0;
  logic          beat = 1'b0;
  logic [SB+IB-1:0] rom_addr;
  logic [15:0]   rom_data = 16'd0;
  logic [5:0]    note_to_load, duration_to_load;
  logic [NV-1:0] load_new_note, done_with_note = '0, voice_busy;
  logic          song_done;

  logic [15:0] rom [0:(1<<(SB+IB))-1];

  int n_checks = 0;
  int n_fail   = 0;

  int m_phase, m_lat, m_beats, m_song, m_idx;
  logic [NV-1:0] m_busy, e_load;
  logic [5:0]    e_note, e_dur;
  logic          m_sdone;
  int songs_finished = 0;

  song_sequencer #(.NUM_VOICES(NV), .SONG_BITS(SB), .IDX_BITS(IB)) dut (
    .clk(clk), .reset(reset), .play(play), .new_song(new_song), .song_sel(song_sel),
    .beat(beat), .rom_addr(rom_addr), .rom_data(rom_data), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .load_new_note(load_new_note),
    .done_with_note(done_with_note), .voice_busy(voice_busy), .song_done(song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input bit e, input bit a, input int n, input int d);
    logic [1:0] rsv;
    rsv = 2'($urandom_range(0, 3));
    return {e, a, rsv, 6'(n), 6'(d)};
  endfunction

  function automatic int lowest_free(input logic [NV-1:0] b);
    for (int i = 0; i < NV; i++) if (!b[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_lat = 0; m_beats = 0; m_song = 0; m_idx = 0;
    m_busy = '0; e_load = '0; e_note = '0; e_dur = '0; m_sdone = 1'b0;
  endtask

  task automatic next_entry();
    if (m_idx == ENTRIES - 1) begin
      m_phase = P_END; m_sdone = 1'b1; songs_finished++;
    end else begin
      m_idx++; m_phase = P_FETCH; m_lat = 2;
    end
  endtask

  // one clock edge of the reference: inputs are those the DUT sampled at this edge
  task automatic model_step();
    logic [NV-1:0] nb;
    logic [15:0] w;
    int v, n, d;
    nb = m_busy & ~done_with_note;
    e_load = '0;
    if (new_song) begin
      m_song = int'(song_sel); m_idx = 0; m_sdone = 1'b0; m_phase = P_FETCH; m_lat = 2;
    end else if (play) begin
      case (m_phase)
        P_FETCH: begin
          m_lat--;
          if (m_lat == 0) m_phase = P_DECIDE;
        end
        P_DECIDE: begin
          w = rom[m_song * ENTRIES + m_idx];
          n = int'(w[11:6]); d = int'(w[5:0]);
          v = lowest_free(m_busy);
          if (w[15]) begin
            m_phase = P_END; m_sdone = 1'b1; songs_finished++;
          end else if (n != 0 && v < 0) begin
            m_phase = P_DECIDE;
          end else begin
            if (n != 0) begin
              e_load = NV'(1) << v; e_note = 6'(n); e_dur = 6'(d);
            end
            if (w[14] && d > 0) begin
              m_beats = d; m_phase = P_BEATS;
            end else begin
              next_entry();
            end
          end
        end
        P_BEATS: begin
          if (beat) begin
            m_beats--;
            if (m_beats == 0) next_entry();
          end
        end
        default: ;
      endcase
    end
    m_busy = nb | e_load;
  endtask

  task automatic check_all(input string ph);
    check_val({ph, ".load"}, 32'(load_new_note), 32'(e_load));
    check_val({ph, ".note"}, 32'(note_to_load), 32'(e_note));
    check_val({ph, ".dur"}, 32'(duration_to_load), 32'(e_dur));
    check_val({ph, ".busy"}, 32'(voice_busy), 32'(m_busy));
    check_val({ph, ".song_done"}, 32'(song_done), 32'(m_sdone));
    check_val({ph, ".rom_addr"}, 32'(rom_addr), 32'(m_song * ENTRIES + m_idx));
  endtask

  initial begin
    int song_order [4] = '{0, 1, 3, 2};
    int order_pos = 0;
    int idle_cnt = 0;
    int pause_left = 0;
    bit did_reset = 1'b0;

    // random songs, then directed content overlaid
    for (int i = 0; i < (1 << (SB + IB)); i++) begin
      rom[i] = mk(1'b0, $urandom_range(0, 2) != 0,
                  ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 63)),
                  int'($urandom_range(0, 4)));
    end
    rom[0] = mk(1'b0, 1'b1, 5, 2);
    rom[1] = mk(1'b1, 1'b0, 0, 0);
    rom[ENTRIES + 0] = mk(1'b0, 1'b0, 10, 4);
    rom[ENTRIES + 1] = mk(1'b0, 1'b0, 14, 4);
    rom[ENTRIES + 2] = mk(1'b0, 1'b0, 17, 4);
    rom[ENTRIES + 3] = mk(1'b0, 1'b1, 20, 3);
    rom[ENTRIES + 4] = mk(1'b0, 1'b1, 0, 3);
    rom[ENTRIES + 12] = mk(1'b1, 1'b0, 0, 0);
    rom[2 * ENTRIES + 20] = mk(1'b1, 1'b0, 0, 0);
    rom[3 * ENTRIES + 0] = mk(1'b0, 1'b1, 0, 3);

    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all("reset");
    reset = 1'b1;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      // asynchronous reset while waiting on beats
      if (!did_reset && cyc > 1500 && m_phase == P_BEATS) begin
        did_reset = 1'b1;
        #2 reset = 1'b0;
        #1 model_reset();
        check_all("midreset");
        new_song = 1'b0; done_with_note = '0;
        @(posedge clk);
        #1 check_all("midreset_hold");
        reset = 1'b1;
      end

      new_song = 1'b0;
      if (m_phase == P_IDLE || m_phase == P_END) begin
        idle_cnt++;
        if (idle_cnt > 3) begin
          new_song = 1'b1;
          song_sel = (order_pos < 4) ? SB'(song_order[order_pos]) : SB'($urandom_range(0, 3));
          order_pos++;
          idle_cnt = 0;
        end
      end else if ($urandom_range(0, 799) == 0) begin
        new_song = 1'b1;
        song_sel = SB'($urandom_range(0, 3));
      end

      if (pause_left > 0) begin
        play = 1'b0; pause_left--;
      end else begin
        play = 1'b1;
        if ($urandom_range(0, 49) == 0) pause_left = $urandom_range(1, 20);
      end

      beat = ($urandom_range(0, 3) == 0);
      for (int v = 0; v < NV; v++)
        done_with_note[v] = m_busy[v] && ($urandom_range(0, 9) == 0);

      @(posedge clk);
      model_step();
      #1 check_all("run");
    end

    check_val("songs_finished_ge3", 32'(songs_finished >= 3), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
